// File: rtl/btn_debouncer.sv
// btn_debouncer: button input conditioner for the 25 MHz top level.
// Synchronises the raw buttons, debounces each one independently with its own
// counter, and presents clean levels plus one-cycle press/release pulses.
// Optional feature macro: BTN_AUTOREPEAT_EN adds per-button auto-repeat of
// btn_press while a button stays held.
module btn_debouncer #(
    parameter int               N_BTN           = 7,
    parameter int               DEBOUNCE_CYCLES = 250000,
    parameter int               CNT_W           = 18,
    parameter logic [N_BTN-1:0] INVERT_MASK     = 7'b0000001,
    parameter int               REPEAT_DELAY    = 12500000,
    parameter int               REPEAT_PERIOD   = 2500000
) (
    input  logic             clk_25mhz,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    // Count value at which a pending change is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1_reg;
    logic [N_BTN-1:0] sync2_reg;
    logic [N_BTN-1:0] sync;

    // Two-flop synchroniser; resets to the idle board level so the logical value is 0.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= INVERT_MASK;
            sync2_reg <= INVERT_MASK;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Logical input: 1 means pressed regardless of board polarity.
    assign sync = sync2_reg ^ INVERT_MASK;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi = gi + 1) begin : g_btn
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;
            logic             press_reg;
            logic             release_reg;
            logic             accept;
            logic             rpt_fire;

            // The pending change has been stable long enough this cycle.
            assign accept = (sync[gi] != level_reg) && (cnt_reg == CNT_LAST);

`ifdef BTN_AUTOREPEAT_EN
            localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RPT_W   = $clog2(RPT_MAX + 1);
            localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
            localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

            logic [RPT_W-1:0] rpt_reg;
            logic             repeating_reg;
            logic [RPT_W-1:0] rpt_target;

            // First repeat waits the long delay, later ones the short period.
            assign rpt_target = repeating_reg ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
            // An accepted transition (release in particular) always wins over a repeat.
            assign rpt_fire   = level_reg && !accept && (rpt_reg == rpt_target);

            // Hold-time counter: cleared on each accepted press and while released.
            always_ff @(posedge clk_25mhz or negedge reset_n) begin
                if (!reset_n) begin
                    rpt_reg       <= '0;
                    repeating_reg <= 1'b0;
                end else if (accept || !level_reg) begin
                    rpt_reg       <= '0;
                    repeating_reg <= 1'b0;
                end else if (rpt_fire) begin
                    rpt_reg       <= '0;
                    repeating_reg <= 1'b1;
                end else begin
                    rpt_reg <= rpt_reg + RPT_W'(1);
                end
            end
`else
            assign rpt_fire = 1'b0;
`endif

            // Debounce: count consecutive cycles of disagreement, accept at the limit.
            always_ff @(posedge clk_25mhz or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= rpt_fire;
                    release_reg <= 1'b0;
                    if (sync[gi] == level_reg) begin
                        cnt_reg <= '0;
                    end else if (accept) begin
                        level_reg   <= sync[gi];
                        press_reg   <= sync[gi];
                        release_reg <= !sync[gi];
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debouncer.sv
// Testbench for btn_debouncer: directed scenarios followed by random button
// activity, every cycle compared against a window-based reference model.
module tb_btn_debouncer;

    localparam int         NB   = 7;
    localparam int         DC   = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 3;
    localparam logic [6:0] MASK = 7'h01;

    logic       clk_25mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic [6:0] btn       = 7'h7F;
    logic [6:0] btn_level;
    logic [6:0] btn_press;
    logic [6:0] btn_release;

    btn_debouncer #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (3),
        .INVERT_MASK    (MASK),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_25mhz  (clk_25mhz),
        .reset_n    (reset_n),
        .btn        (btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: captured logical inputs, window of values seen by the
    // debouncer, expected outputs, and hold time since the last accepted press.
    logic [6:0] cap_q[$];
    logic [6:0] win_q[$];
    logic [6:0] m_level, m_press, m_release;
    int         held[NB];

    int press_cnt[NB], rel_cnt[NB], last_press[NB], last_rel[NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cap_q = {};
        cap_q.push_back(7'h00);
        cap_q.push_back(7'h00);
        win_q = {};
        for (int j = 0; j < DC; j++) win_q.push_back(7'h00);
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        for (int b = 0; b < NB; b++) held[b] = 0;
    endtask

    // A level flips once the last DC values seen all differ from it.
    task automatic model_edge();
        logic [6:0] seen;
        logic       flip;
        if (!reset_n) return;
        seen = cap_q[0];
        cap_q.push_back(btn ^ MASK);
        void'(cap_q.pop_front());
        win_q.push_back(seen);
        void'(win_q.pop_front());
        m_press   = '0;
        m_release = '0;
        for (int b = 0; b < NB; b++) begin
            flip = 1'b1;
            foreach (win_q[j]) if (win_q[j][b] == m_level[b]) flip = 1'b0;
            if (flip) begin
                m_level[b] = ~m_level[b];
                if (m_level[b]) begin
                    m_press[b] = 1'b1;
                    held[b]    = 0;
                end else begin
                    m_release[b] = 1'b1;
                end
            end else if (m_level[b]) begin
                held[b]++;
`ifdef BTN_AUTOREPEAT_EN
                if (held[b] == RD || (held[b] > RD && (held[b] - RD) % RP == 0))
                    m_press[b] = 1'b1;
`endif
            end
        end
    endtask

    task automatic step();
        @(posedge clk_25mhz);
        cyc++;
        model_edge();
        #1;
        chk("level", btn_level, m_level);
        chk("press", btn_press, m_press);
        chk("release", btn_release, m_release);
        for (int b = 0; b < NB; b++) begin
            if (btn_press[b] === 1'b1)   begin press_cnt[b]++; last_press[b] = cyc; end
            if (btn_release[b] === 1'b1) begin rel_cnt[b]++;   last_rel[b]   = cyc; end
        end
    endtask

    initial begin
        int k, m, r, p0, r0, p_cyc, exp_cnt, tot;
        for (int b = 0; b < NB; b++) begin
            press_cnt[b] = 0; rel_cnt[b] = 0; last_press[b] = -1; last_rel[b] = -1;
        end
        model_reset();

        // Reset held with every pin high
        #1;
        chk("rst_level", btn_level, 7'h00);
        chk("rst_press", btn_press, 7'h00);
        chk("rst_release", btn_release, 7'h00);
        repeat (3) step();
        reset_n = 1'b1;
        btn     = 7'h01;
        repeat (20) step();
        tot = 0;
        for (int b = 0; b < NB; b++) tot += press_cnt[b] + rel_cnt[b];
        chk("idle_pulses", tot, 0);

        // Clean press and release on btn[1]
        btn[1] = 1'b1; k = cyc + 1; p0 = press_cnt[1];
        repeat (8) step();
        chk("press1_cycle", last_press[1], k + 5);
        chk("press1_count", press_cnt[1] - p0, 1);
        btn[1] = 1'b0; m = cyc + 1; r0 = rel_cnt[1];
        repeat (8) step();
        chk("release1_cycle", last_rel[1], m + 5);
        chk("release1_count", rel_cnt[1] - r0, 1);

        // Bouncing btn[2], then a clean hold
        p0 = press_cnt[2];
        for (int i = 0; i < 10; i++) begin
            btn[2] = ~btn[2];
            repeat (2) step();
        end
        chk("bounce_count", press_cnt[2] - p0, 0);
        chk("bounce_level", btn_level[2], 1'b0);
        btn[2] = 1'b1; k = cyc + 1;
        repeat (8) step();
        chk("bounce_press_count", press_cnt[2] - p0, 1);
        chk("bounce_press_cycle", last_press[2], k + 5);

        // Three-cycle glitch on btn[3]
        p0 = press_cnt[3]; r0 = rel_cnt[3];
        btn[3] = 1'b1;
        repeat (3) step();
        btn[3] = 1'b0;
        repeat (8) step();
        chk("glitch_pulses", (press_cnt[3] - p0) + (rel_cnt[3] - r0), 0);

        // Simultaneous press of btn[1] and release of btn[4]
        btn[4] = 1'b1;
        repeat (8) step();
        btn[1] = 1'b1; btn[4] = 1'b0; k = cyc + 1;
        repeat (8) step();
        chk("simul_press1", last_press[1], k + 5);
        chk("simul_release4", last_rel[4], k + 5);

        // Reset in the middle of qualifying btn[5]
        btn[5] = 1'b1; k = cyc + 1; p0 = press_cnt[5];
        repeat (3) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_level", btn_level, 7'h00);
        chk("midrst_no_press", press_cnt[5] - p0, 0);
        repeat (3) step();
        reset_n = 1'b1; r = cyc + 1;
        repeat (8) step();
        chk("postrst_count", press_cnt[5] - p0, 1);
        chk("postrst_cycle", last_press[5], r + 5);

        // Long hold on btn[6]
        btn[6] = 1'b1; k = cyc + 1; p_cyc = k + 5;
        p0 = press_cnt[6]; r0 = rel_cnt[6];
        while (cyc < p_cyc + 30) step();
        btn[6] = 1'b0; m = cyc + 1;
        repeat (8) step();
        exp_cnt = 1;
`ifdef BTN_AUTOREPEAT_EN
        for (int j = RD; j < m + 5 - p_cyc; j++) if ((j - RD) % RP == 0) exp_cnt++;
`endif
        chk("hold6_press_count", press_cnt[6] - p0, exp_cnt);
        chk("hold6_release_count", rel_cnt[6] - r0, 1);
        chk("hold6_release_cycle", last_rel[6], m + 5);

        // Random activity with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 5) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 149) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                chk("rand_rst_level", btn_level, 7'h00);
                step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
# btn_debouncer

Button input conditioner for the 25 MHz top level. Synchronises the raw board buttons, debounces each one independently, and presents clean levels plus one-cycle press/release pulses. It is the producing end of the button interface: the LED shifter and similar consumers take its pulses in place of raw `btn` bits.

## Interface

Parameters:
- `N_BTN`, 7: number of buttons.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before a change is accepted (10 ms at 25 MHz). Must be ≥ 2.
- `CNT_W`, 18: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `INVERT_MASK`, 7'b0000001: bits set here are active-low on the board (btn[0] is the PWR button).
- `REPEAT_DELAY`, 12500000: hold time before auto-repeat starts, in cycles (0.5 s).
- `REPEAT_PERIOD`, 2500000: auto-repeat interval, in cycles (0.1 s).

Ports:
- `clk_25mhz` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn` in N_BTN: raw, asynchronous button pins.
- `btn_level` out N_BTN: debounced logical level; 1 means pressed.
- `btn_press` out N_BTN: one-cycle pulse on each accepted press, and on each auto-repeat.
- `btn_release` out N_BTN: one-cycle pulse on each accepted release.

## Operation

- **Synchroniser.** Two flops per bit. Both reset to `INVERT_MASK`, so the logical value after reset is 0.
- **Logical input.** `sync = sync2 ^ INVERT_MASK`.
- **Debounce, per button, independent counter `cnt`.**
  - If `sync == btn_level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`:
    - `btn_level <= sync`.
    - Pulse `btn_press` if `sync` is 1, else pulse `btn_release`.
    - `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Glitches.** Any single cycle where `sync` equals `btn_level` discards the accumulated count. Glitches shorter than `DEBOUNCE_CYCLES` never reach the outputs.
- **Pulses.** Registered, high for exactly one cycle. `btn_press` and `btn_release` are never high together for the same bit.
- **Multiple buttons.** Buttons are fully independent; any combination of bits may pulse in the same cycle.
- **Reset values.**
  - `btn_level`, `btn_press`, `btn_release`: all 0.
  - All counters: 0.
  - Synchroniser flops: `INVERT_MASK`.
- **Reset during operation.** Asserting `reset_n` during a count aborts it immediately and asynchronously. No pulse is emitted for the aborted transition. After release, the button re-qualifies from a count of 0.
- **Held at reset release.** A button already held when reset releases is reported as a fresh press after the normal debounce latency.

## Timing

- Edge k is the first rising edge at which `sync1` captures a new raw value, with the raw value held stable afterwards.
- `sync2` reflects the new value from edge k+1.
- `btn_level` changes, and the matching pulse is asserted, at edge k+1+DEBOUNCE_CYCLES. Total latency is DEBOUNCE_CYCLES+1 edges after capture.
- The pulse deasserts at the next edge.
- The debounce counter saturates implicitly: it is reset to 0 on acceptance, so it never wraps.

## Configuration

- Macro: `BTN_AUTOREPEAT_EN`.
- **Defined.** Each button gets an additional repeat counter, cleared on every accepted press and while `btn_level` is 0.
  - While held, an extra `btn_press` pulse fires REPEAT_DELAY cycles after the original press pulse.
  - Further pulses then fire every REPEAT_PERIOD cycles.
  - Release stops repeating immediately; no repeat pulse may coincide with `btn_release`.
- **Undefined.** No repeat logic is synthesised. `btn_press` fires once per accepted press. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan

Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.

- **Reset.** Hold `reset_n`=0 with `btn`=7'h7F → all outputs 0. Release with `btn`=7'h01 → outputs stay 0 for 20 cycles (btn[0] idle, since it is active-low).
- **Clean press/release.** Raise btn[1], captured at edge k → `btn_level[1]`=1 and a single-cycle `btn_press[1]` at edge k+5. Drop btn[1] at capture edge m → `btn_release[1]` at m+5.
- **Bounce and glitch.**
  - Toggle btn[2] every 2 cycles for 20 cycles, then hold 1 → no output activity during the bouncing; exactly one `btn_press[2]` 5 edges after the final capture.
  - Pulse btn[3] high for 3 cycles → no output change.
- **Simultaneous events.** With btn[4] pressed and settled, raise btn[1] and drop btn[4] in the same cycle → `btn_press[1]` and `btn_release[4]` are asserted in the same cycle.
- **Reset during operation.** Raise btn[5]; assert `reset_n` 2 cycles after capture; release it 3 cycles later with btn[5] still high → no pulse before reset. `btn_press[5]` fires 5 edges after the first post-reset capture.
- **Auto-repeat (macro defined).** Hold btn[6] for 30 cycles after its press pulse at cycle P → `btn_press[6]` at P, P+10, P+13, P+16, … At release, a single `btn_release[6]` and no further presses. With the macro undefined → only the pulse at P.
